// File: rtl/ir_receiver.sv
// ir_receiver -- decodes the demodulated IR photodiode level into messages.
//
// Line protocol (one slot = SLOT_CYCLES clocks):
//   each bit = 1-slot start-high, 2 slots high (1) or low (0), 1 slot low;
//   LSB first, MSG_BITS bits per message, >= 3 idle-low slots between messages.
// Pulse widths are measured with a saturating cycle counter.
// High width in [HALF, TWO) decodes as 0 and [TWO, FOUR) as 1. Any other
// high width is a protocol error. A low gap inside a message must be in
// [HALF, FOUR).
//
// Optional build macro: IR_RX_GLITCH_FILTER_EN
//   When defined, a stability filter (FILTER_CYCLES) sits between the
//   synchronizer and the FSM. Pulses and dropouts shorter than the window
//   never reach the FSM. Both edges are delayed equally, so widths are kept.
//
// Ports:
//   CLK        in   system clock (100 MHz nominal)
//   INV_RESET  in   asynchronous active-low reset
//   IR_IN      in   demodulated IR level, asynchronous to CLK
//   MSG        out  last correctly received message, held until the next one
//   MSG_VALID  out  one-cycle pulse when MSG updates
//   RX_ERR     out  one-cycle pulse on protocol violation
//   RX_BUSY    out  high whenever the FSM is not idle
module ir_receiver #(
   parameter int SLOT_CYCLES = 20000,
   parameter int MSG_BITS    = 8
`ifdef IR_RX_GLITCH_FILTER_EN
   ,
   parameter int FILTER_CYCLES = 16
`endif
) (
   input  logic                CLK,
   input  logic                INV_RESET,
   input  logic                IR_IN,
   output logic [MSG_BITS-1:0] MSG,
   output logic                MSG_VALID,
   output logic                RX_ERR,
   output logic                RX_BUSY
);

   localparam logic [31:0] HALF    = 32'(SLOT_CYCLES / 2);
   localparam logic [31:0] TWO     = 32'(2 * SLOT_CYCLES);
   localparam logic [31:0] FOUR    = 32'(4 * SLOT_CYCLES);
   localparam logic [31:0] FOUR_M1 = FOUR - 32'd1;
   localparam int          BC_W    = $clog2(MSG_BITS + 1);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(MSG_BITS - 1);

   typedef enum logic [1:0] {IDLE, HIGH, LOW, ERROR} state_t;

   state_t              state, state_nxt;
   logic [31:0]         cnt, cnt_nxt, cnt_inc;
   logic [MSG_BITS-1:0] shreg, shreg_nxt;
   logic [BC_W-1:0]     bit_cnt, bit_cnt_nxt;
   logic                load_msg, enter_err, new_bit;
   logic                sync1, ir_s, ir_l;

   // Two-flop synchronizer. The latency is the same on both edges, so the
   // measured widths are not changed.
   // NOTE: clocked state uses non-blocking (<=) so every flop samples the
   // pre-edge value; blocking here would collapse the two stages into one.
   always_ff @(posedge CLK or negedge INV_RESET) begin
      if (!INV_RESET) begin
         sync1 <= 1'b0;
         ir_s  <= 1'b0;
      end else begin
         sync1 <= IR_IN;
         ir_s  <= sync1;
      end
   end

`ifdef IR_RX_GLITCH_FILTER_EN
   localparam int FC_W = $clog2(FILTER_CYCLES + 1);
   logic [FC_W-1:0] filt_cnt;
   logic            filt;

   // The output follows the input only after the input has differed from it
   // for FILTER_CYCLES consecutive cycles. Any agreement restarts the count.
   always_ff @(posedge CLK or negedge INV_RESET) begin
      if (!INV_RESET) begin
         filt     <= 1'b0;
         filt_cnt <= '0;
      end else if (ir_s == filt) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FC_W'(FILTER_CYCLES - 1)) begin
         filt     <= ir_s;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + FC_W'(1);
      end
   end

   assign ir_l = filt;
`else
   assign ir_l = ir_s;
`endif

   assign cnt_inc = (cnt == '1) ? cnt : cnt + 32'd1;
   assign new_bit = (cnt >= TWO);

   // The error-limit checks fire while the counter holds FOUR-1 and the
   // level is still present. This makes a width of exactly FOUR an error
   // before the edge arrives.
   // NOTE: every signal this block drives gets a default first, so no
   // path through the case can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt;
      load_msg    = 1'b0;
      case (state)
         IDLE: begin
            if (ir_l) begin
               state_nxt   = HIGH;
               cnt_nxt     = 32'd1;
               bit_cnt_nxt = '0;
            end
         end
         HIGH: begin
            if (ir_l) begin
               if (cnt >= FOUR_M1) begin
                  state_nxt = ERROR;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end else if (cnt < HALF || cnt >= FOUR) begin
               state_nxt = ERROR;
               cnt_nxt   = '0;
            end else begin
               shreg_nxt   = {new_bit, shreg[MSG_BITS-1:1]};
               bit_cnt_nxt = bit_cnt + BC_W'(1);
               if (bit_cnt == LAST_BIT) begin
                  load_msg  = 1'b1;
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else begin
                  state_nxt = LOW;
                  cnt_nxt   = 32'd1;
               end
            end
         end
         LOW: begin
            if (!ir_l) begin
               if (cnt >= FOUR_M1) begin
                  state_nxt = ERROR;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end else if (cnt < HALF) begin
               state_nxt = ERROR;
               cnt_nxt   = '0;
            end else begin
               state_nxt = HIGH;
               cnt_nxt   = 32'd1;
            end
         end
         ERROR: begin
            // Leave only after FOUR consecutive low cycles. Any high
            // restarts the count.
            if (ir_l) begin
               cnt_nxt = '0;
            end else if (cnt >= FOUR_M1) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign enter_err = (state_nxt == ERROR) && (state != ERROR);

   always_ff @(posedge CLK or negedge INV_RESET) begin
      if (!INV_RESET) begin
         state     <= IDLE;
         cnt       <= '0;
         shreg     <= '0;
         bit_cnt   <= '0;
         MSG       <= '0;
         MSG_VALID <= 1'b0;
         RX_ERR    <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         shreg     <= shreg_nxt;
         bit_cnt   <= bit_cnt_nxt;
         MSG_VALID <= load_msg;
         RX_ERR    <= enter_err;
         if (load_msg) MSG <= shreg_nxt;
      end
   end

   assign RX_BUSY = (state != IDLE);

endmodule

// File: tb/tb_ir_receiver.sv
// tb_ir_receiver -- self-checking bench for ir_receiver.
// Runs with SLOT_CYCLES=20 (HALF=10, TWO=40, FOUR=80). It drives IR_IN
// from tables of high/low widths. A width-level protocol model predicts
// the decoded message or an error.
// Ports of the DUT are connected by name: CLK, INV_RESET, IR_IN, MSG,
// MSG_VALID, RX_ERR, RX_BUSY.
module tb_ir_receiver;
   localparam int SLOT = 20;
   localparam int HALF = SLOT / 2;
   localparam int TWO  = 2 * SLOT;
   localparam int FOUR = 4 * SLOT;
`ifdef IR_RX_GLITCH_FILTER_EN
   localparam int FILT = 8;
`else
   localparam int FILT = 0;
`endif
   localparam int LAT = 3 + FILT;

   logic       CLK = 1'b0;
   logic       INV_RESET = 1'b0;
   logic       IR_IN = 1'b0;
   logic [7:0] MSG;
   logic       MSG_VALID, RX_ERR, RX_BUSY;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_fall = 0;
   int last_good = 0;

   // monitor state
   int         valid_cnt = 0;
   int         err_cnt = 0;
   int         overlap_cnt = 0;
   int         valid_cyc = 0;
   logic [7:0] msg_q[$];

   ir_receiver #(
      .SLOT_CYCLES(SLOT),
      .MSG_BITS(8)
`ifdef IR_RX_GLITCH_FILTER_EN
      , .FILTER_CYCLES(FILT)
`endif
   ) dut (
      .CLK(CLK),
      .INV_RESET(INV_RESET),
      .IR_IN(IR_IN),
      .MSG(MSG),
      .MSG_VALID(MSG_VALID),
      .RX_ERR(RX_ERR),
      .RX_BUSY(RX_BUSY)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (MSG_VALID) begin
         valid_cnt <= valid_cnt + 1;
         valid_cyc <= cyc;
         msg_q.push_back(MSG);
      end
      if (RX_ERR) err_cnt <= err_cnt + 1;
      if (MSG_VALID && RX_ERR) overlap_cnt <= overlap_cnt + 1;
   end

   // Protocol model: returns the decoded byte, or -1 on a violation.
   // The trailing low of the last bit belongs to the idle gap.
   function automatic int model_msg(input int hw[8], input int lw[8]);
      int v = 0;
      for (int i = 0; i < 8; i++) begin
         if (hw[i] < HALF || hw[i] >= FOUR) return -1;
         if (hw[i] >= TWO) v = v | (1 << i);
         if (i < 7 && (lw[i] < HALF || lw[i] >= FOUR)) return -1;
      end
      return v;
   endfunction

   // An isolated high pulse in idle: invisible if shorter than the filter
   // window, otherwise an error if shorter than HALF.
   function automatic int model_glitch_err(input int w);
      if (w < FILT) return 0;
      return (w < HALF) ? 1 : 0;
   endfunction

   task automatic idle(input int n);
      IR_IN = 1'b0;
      repeat (n) @(negedge CLK);
   endtask

   task automatic make_exact(input logic [7:0] b, output int hw[8], output int lw[8]);
      for (int i = 0; i < 8; i++) begin
         hw[i] = b[i] ? 3 * SLOT : SLOT;
         lw[i] = b[i] ? SLOT : 3 * SLOT;
      end
   endtask

   task automatic send_bits(input int hw[8], input int lw[8], input int first, input int last);
      for (int i = first; i <= last; i++) begin
         IR_IN = 1'b1;
         repeat (hw[i]) @(negedge CLK);
         IR_IN = 1'b0;
         last_fall = cyc;
         repeat (lw[i]) @(negedge CLK);
      end
   endtask

   task automatic test_reset();
      INV_RESET = 1'b0;
      IR_IN = 1'b0;
      repeat (3) @(negedge CLK);
      if (MSG !== 8'h00) begin errors++; $display("FAIL reset_msg: got %h want 00", MSG); end
      checks++;
      if (MSG_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", MSG_VALID); end
      checks++;
      if (RX_ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", RX_ERR); end
      checks++;
      if (RX_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", RX_BUSY); end
      checks++;
      INV_RESET = 1'b1;
      idle(5);
   endtask

   task automatic test_exact_a5();
      int hw[8], lw[8];
      int v0, e0, exp;
      v0 = valid_cnt; e0 = err_cnt;
      make_exact(8'hA5, hw, lw);
      exp = model_msg(hw, lw);
      send_bits(hw, lw, 0, 0);
      if (RX_BUSY !== 1'b1) begin errors++; $display("FAIL a5_busy_mid: got %b want 1", RX_BUSY); end
      checks++;
      send_bits(hw, lw, 1, 7);
      idle(20);
      if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL a5_valid_count: got %0d want 1", valid_cnt - v0); end
      checks++;
      if (MSG !== exp[7:0]) begin errors++; $display("FAIL a5_msg: got %h want %h", MSG, exp[7:0]); end
      checks++;
      if (valid_cyc - last_fall !== LAT) begin errors++; $display("FAIL a5_latency: got %0d want %0d", valid_cyc - last_fall, LAT); end
      checks++;
      if (RX_BUSY !== 1'b0) begin errors++; $display("FAIL a5_busy_after: got %b want 0", RX_BUSY); end
      checks++;
      if (err_cnt !== e0) begin errors++; $display("FAIL a5_no_err: got %0d want %0d", err_cnt, e0); end
      checks++;
      last_good = exp;
   endtask

   task automatic test_back_to_back();
      int hw[8], lw[8];
      int e0;
      e0 = err_cnt;
      msg_q.delete();
      make_exact(8'h00, hw, lw);
      send_bits(hw, lw, 0, 7);
      idle(60);
      make_exact(8'hFF, hw, lw);
      send_bits(hw, lw, 0, 7);
      idle(20);
      if (msg_q.size() !== 2) begin
         errors++; $display("FAIL b2b_count: got %0d want 2", msg_q.size());
      end else begin
         if (msg_q[0] !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h want 00", msg_q[0]); end
         checks++;
         if (msg_q[1] !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h want ff", msg_q[1]); end
      end
      checks++;
      if (err_cnt !== e0) begin errors++; $display("FAIL b2b_no_err: got %0d want %0d", err_cnt, e0); end
      checks++;
      last_good = 8'hFF;
   endtask

   task automatic test_jitter_3c();
      int hw[8] = '{12, 38, 40, 79, 79, 40, 38, 12};
      int lw[8] = '{10, 79, 45, 10, 79, 20, 60, 30};
      int v0, e0, exp;
      v0 = valid_cnt; e0 = err_cnt;
      exp = model_msg(hw, lw);
      send_bits(hw, lw, 0, 7);
      idle(20);
      if (MSG !== exp[7:0]) begin errors++; $display("FAIL jit_msg: got %h want %h", MSG, exp[7:0]); end
      checks++;
      if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL jit_valid_count: got %0d want 1", valid_cnt - v0); end
      checks++;
      if (err_cnt !== e0) begin errors++; $display("FAIL jit_no_err: got %0d want %0d", err_cnt, e0); end
      checks++;
      last_good = exp;
   endtask

   task automatic test_random();
      for (int n = 0; n < 10; n++) begin
         int hw[8], lw[8];
         int v0, e0, exp, k;
         logic [7:0] b;
         b = 8'($urandom);
         for (int i = 0; i < 8; i++) begin
            k = $urandom_range(0, 3);
            if (b[i]) hw[i] = (k == 0) ? TWO : (k == 1) ? FOUR - 1 : $urandom_range(TWO, FOUR - 1);
            else      hw[i] = (k == 0) ? HALF : (k == 1) ? TWO - 1 : $urandom_range(HALF, TWO - 1);
            k = $urandom_range(0, 3);
            lw[i] = (k == 0) ? HALF : (k == 1) ? FOUR - 1 : $urandom_range(HALF, FOUR - 1);
         end
         if (n % 2 == 1 && $urandom_range(0, 1) == 1) begin
            k = $urandom_range(0, 6);
            if ($urandom_range(0, 1) == 1) hw[k] = $urandom_range(8, HALF - 1);
            else                           lw[k] = $urandom_range(8, HALF - 1);
         end
         exp = model_msg(hw, lw);
         v0 = valid_cnt; e0 = err_cnt;
         send_bits(hw, lw, 0, 7);
         idle(200);
         if (exp < 0) begin
            if (err_cnt - e0 !== 1) begin errors++; $display("FAIL rnd_err_count n=%0d: got %0d want 1", n, err_cnt - e0); end
            checks++;
            if (valid_cnt !== v0) begin errors++; $display("FAIL rnd_err_novalid n=%0d: got %0d want 0", n, valid_cnt - v0); end
            checks++;
            if (MSG !== last_good[7:0]) begin errors++; $display("FAIL rnd_err_msg_held n=%0d: got %h want %h", n, MSG, last_good[7:0]); end
            checks++;
         end else begin
            if (MSG !== exp[7:0]) begin errors++; $display("FAIL rnd_msg n=%0d: got %h want %h", n, MSG, exp[7:0]); end
            checks++;
            if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL rnd_valid n=%0d: got %0d want 1", n, valid_cnt - v0); end
            checks++;
            if (err_cnt !== e0) begin errors++; $display("FAIL rnd_no_err n=%0d: got %0d want 0", n, err_cnt - e0); end
            checks++;
            last_good = exp;
         end
      end
   endtask

   task automatic test_stuck_high();
      int hw[8], lw[8];
      int v0, e0;
      make_exact(8'h5A, hw, lw);
      send_bits(hw, lw, 0, 7);
      idle(20);
      if (MSG !== 8'h5A) begin errors++; $display("FAIL stuck_pre_msg: got %h want 5a", MSG); end
      checks++;
      v0 = valid_cnt; e0 = err_cnt;
      IR_IN = 1'b1;
      repeat (FOUR) @(negedge CLK);
      idle(FOUR);
      if (err_cnt - e0 !== 1) begin errors++; $display("FAIL stuck_err: got %0d want 1", err_cnt - e0); end
      checks++;
      if (MSG !== 8'h5A) begin errors++; $display("FAIL stuck_msg_held: got %h want 5a", MSG); end
      checks++;
      if (valid_cnt !== v0) begin errors++; $display("FAIL stuck_no_valid: got %0d want 0", valid_cnt - v0); end
      checks++;
      make_exact(8'h11, hw, lw);
      send_bits(hw, lw, 0, 7);
      idle(20);
      if (MSG !== 8'h11) begin errors++; $display("FAIL stuck_recover: got %h want 11", MSG); end
      checks++;
      last_good = 8'h11;
   endtask

   task automatic test_timeout();
      int hw[8], lw[8];
      int v0, e0;
      make_exact(8'hFF, hw, lw);
      lw[2] = FOUR;
      v0 = valid_cnt; e0 = err_cnt;
      send_bits(hw, lw, 0, 2);
      idle(120);
      if (err_cnt - e0 !== 1) begin errors++; $display("FAIL tmo_err: got %0d want 1", err_cnt - e0); end
      checks++;
      if (valid_cnt !== v0) begin errors++; $display("FAIL tmo_no_valid: got %0d want 0", valid_cnt - v0); end
      checks++;
      make_exact(8'hC3, hw, lw);
      send_bits(hw, lw, 0, 7);
      idle(20);
      if (MSG !== 8'hC3) begin errors++; $display("FAIL tmo_recover: got %h want c3", MSG); end
      checks++;
      last_good = 8'hC3;
   endtask

   task automatic test_reset_mid();
      int hw[8], lw[8];
      int v0;
      make_exact(8'hFF, hw, lw);
      send_bits(hw, lw, 0, 3);
      if (RX_BUSY !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", RX_BUSY); end
      checks++;
      INV_RESET = 1'b0;
      #1;
      if (MSG !== 8'h00) begin errors++; $display("FAIL rstmid_msg: got %h want 00", MSG); end
      checks++;
      if (RX_BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", RX_BUSY); end
      checks++;
      if (MSG_VALID !== 1'b0 || RX_ERR !== 1'b0) begin
         errors++; $display("FAIL rstmid_pulses: got valid=%b err=%b want 0 0", MSG_VALID, RX_ERR);
      end
      checks++;
      @(negedge CLK);
      INV_RESET = 1'b1;
      idle(10);
      v0 = valid_cnt;
      make_exact(8'h81, hw, lw);
      send_bits(hw, lw, 0, 7);
      idle(20);
      if (MSG !== 8'h81) begin errors++; $display("FAIL rstmid_next_msg: got %h want 81", MSG); end
      checks++;
      if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL rstmid_next_valid: got %0d want 1", valid_cnt - v0); end
      checks++;
      last_good = 8'h81;
   endtask

   task automatic test_glitch();
      int hw[8], lw[8];
      int e0, exp_err;
      e0 = err_cnt;
      exp_err = model_glitch_err(5);
      IR_IN = 1'b1;
      repeat (5) @(negedge CLK);
      idle(200);
      if (err_cnt - e0 !== exp_err) begin errors++; $display("FAIL glitch_err: got %0d want %0d", err_cnt - e0, exp_err); end
      checks++;
      make_exact(8'h7E, hw, lw);
      send_bits(hw, lw, 0, 7);
      idle(20);
      if (MSG !== 8'h7E) begin errors++; $display("FAIL glitch_next_msg: got %h want 7e", MSG); end
      checks++;
   endtask

   task automatic test_exclusive();
      if (overlap_cnt !== 0) begin errors++; $display("FAIL valid_err_overlap: got %0d cycles want 0", overlap_cnt); end
      checks++;
   endtask

   initial begin
      test_reset();
      test_exact_a5();
      test_back_to_back();
      test_jitter_3c();
      test_random();
      test_stuck_high();
      test_timeout();
      test_reset_mid();
      test_glitch();
      test_exclusive();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ir_receiver.md
Name: ir_receiver

Overview:
- Receive-side counterpart of the IR LED transmitter: decodes the demodulated IR photodiode level back into 8-bit messages.
- Sits directly downstream of the IR link: IR_IN comes from the external 38 kHz demodulator; MSG/MSG_VALID feed the game-state logic.
- Runs on the 100 MHz system clock and times pulses with a cycle counter; it does not use a divided clock.
- Line protocol, one slot = 200 us:
  - Each bit is a 1-slot start-high, then 2 slots high (bit = 1) or low (bit = 0), then 1 slot low.
  - Bits are sent LSB first, 8 bits per message, with at least 3 idle-low slots between messages.

Parameters:
- SLOT_CYCLES, 20000, CLK cycles per protocol slot (200 us at 100 MHz).
- MSG_BITS, 8, bits per message.
- FILTER_CYCLES, 16, stability window for the optional glitch filter.

Ports:
- CLK  in  1  system clock.
- INV_RESET  in  1  asynchronous, active-low reset.
- IR_IN  in  1  demodulated IR level, 1 = carrier present; asynchronous to CLK.
- MSG  out  MSG_BITS  last correctly received message; held until the next one is received.
- MSG_VALID  out  1  one-cycle pulse when MSG updates.
- RX_ERR  out  1  one-cycle pulse on protocol violation.
- RX_BUSY  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, INV_RESET=0): clears the following, with no partial byte surviving a reset mid-operation:
  - state=IDLE, MSG=0, MSG_VALID=0, RX_ERR=0;
  - shift register=0, bit count=0, cnt=0;
  - synchronizer flops=0.
- Input path: IR_IN goes through a 2-flop synchronizer to give ir_s, adding 2 cycles of latency. This latency is identical on both edges, so measured widths are preserved.
- Counter cnt: 32-bit, saturating. Set to 1 on entering HIGH or LOW, incremented every cycle in that state. At a level change, cnt equals the number of cycles the level was held.
- Thresholds (integer arithmetic): HALF=SLOT_CYCLES/2, TWO=2*SLOT_CYCLES, FOUR=4*SLOT_CYCLES.
- IDLE:
  - ir_s=1 -> HIGH, with bit count=0.
- HIGH:
  - cnt reaches FOUR while still high -> ERROR (stuck high).
  - ir_s=0 with cnt<HALF -> ERROR (glitch).
  - ir_s=0 with HALF<=cnt<TWO -> bit 0.
  - ir_s=0 with TWO<=cnt<FOUR -> bit 1.
  - On a valid bit: shift in MSB-side, shreg <= {bit, shreg[MSG_BITS-1:1]}, and increment bit count.
  - If this was bit MSG_BITS: MSG<=new shreg, MSG_VALID=1 for the next cycle, -> IDLE. Otherwise -> LOW.
- LOW:
  - cnt reaches FOUR while still low -> ERROR (mid-byte timeout). The maximum legal gap is 3 slots.
  - ir_s=1 with cnt<HALF -> ERROR.
  - ir_s=1 otherwise -> HIGH.
- ERROR:
  - RX_ERR pulses for exactly one cycle on entry; the partial byte is discarded and MSG is unchanged.
  - Stays in ERROR until ir_s has been low for FOUR consecutive cycles (any high restarts the count), then -> IDLE.
- Latency: MSG_VALID rises 3 cycles after the IR_IN falling edge of the last bit (2 sync + 1 register).
- Boundaries:
  - Width exactly HALF is a legal 0.
  - Width exactly TWO is a 1.
  - Width FOUR is always an error.
- MSG_VALID and RX_ERR are never high in the same cycle.
- Back-to-back messages need no idle gap beyond HALF.

Optional Feature:
- Macro: IR_RX_GLITCH_FILTER_EN.
- Defined:
  - A filter stage sits after the synchronizer. Its output changes only after the synchronized input has differed from it for FILTER_CYCLES consecutive cycles.
  - This adds FILTER_CYCLES cycles of latency on both edges, so widths are unchanged.
  - Pulses and dropouts shorter than FILTER_CYCLES are invisible to the FSM.
- Undefined: the FSM uses ir_s directly, and any short pulse causes ERROR via the HALF rule.

Test Plan (bench overrides SLOT_CYCLES=20, so HALF=10, TWO=40, FOUR=80):
1. Send 0xA5 with exact slot timing -> MSG=0xA5, MSG_VALID pulses exactly once, 3 cycles after the final falling edge; RX_BUSY low afterwards.
2. Send 0x00 then 0xFF separated by 60 idle cycles -> two MSG_VALID pulses with MSG=0x00 then 0xFF; RX_ERR never asserted.
3. Jittered 0x3C (0-bit highs 12 and 38 cycles, 1-bit highs 40 and 79, gaps 10 to 79) -> MSG=0x3C, no RX_ERR.
4. After 0x5A, hold IR_IN high 80 cycles -> RX_ERR pulse, MSG stays 0x5A. Then 80 low cycles followed by 0x11 -> MSG=0x11.
5. Send 3 bits, then IR_IN low 80 cycles -> RX_ERR pulse, no MSG_VALID. A following 0xC3 decodes correctly. Separately: pull INV_RESET low after 4 bits -> all outputs 0 immediately, and the next 0x81 decodes correctly.
6. A 5-cycle high glitch in IDLE -> RX_ERR without the macro. With IR_RX_GLITCH_FILTER_EN and FILTER_CYCLES=8 -> no RX_ERR, and a following 0x7E decodes correctly.
